// File: rtl/prog_loader.sv
// UART-fed program loader: the first byte is a length, the following bytes are written to
// sequential RAM addresses, then the CPU is released from reset.
`timescale 1ns/1ps
module prog_loader #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_reload,
  output logic [7:0] o_ramAddress,
  output logic [7:0] o_ramWriteData,
  output logic       o_ramWriteEn,
  output logic       o_cpuReset,
  output logic       o_busy,
  output logic       o_frameErr
);

  localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] BIT_M1  = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {LD_WAIT_LEN, LD_LOAD, LD_DONE} ldState_t;

  // Reset asserts asynchronously but releases two edges later, so no state
  // moves on the edges immediately after deassertion.
  logic rstMeta, rstSyncN;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      rstMeta  <= 1'b0;
      rstSyncN <= 1'b0;
    end else begin
      rstMeta  <= 1'b1;
      rstSyncN <= rstMeta;
    end

  logic        rxMeta, rxSync, rxPrev;
  rxState_t    rxState, rxStateNext;
  logic [11:0] rxCnt, rxCntNext;
  logic [2:0]  bitIdx, bitIdxNext;
  logic [7:0]  shiftReg, shiftNext;
  logic        byteValid, byteValidNext, frameSet;

  ldState_t    ldState, ldStateNext;
  logic [7:0]  idx, idxNext, addrNext, dataNext;
  logic [8:0]  rem, remNext;
  logic        weNext, frameErrNext;

  always_comb begin
    rxStateNext   = rxState;
    rxCntNext     = rxCnt + 12'd1;
    bitIdxNext    = bitIdx;
    shiftNext     = shiftReg;
    byteValidNext = 1'b0;
    frameSet      = 1'b0;
    case (rxState)
      RX_IDLE: begin
        rxCntNext = '0;
        if (rxPrev && !rxSync) rxStateNext = RX_START;
      end
      RX_START:
        if (rxCnt == HALF_M1) begin
          rxCntNext   = '0;
          bitIdxNext  = '0;
          rxStateNext = rxSync ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (rxCnt == BIT_M1) begin
          rxCntNext  = '0;
          shiftNext  = {rxSync, shiftReg[7:1]};
          bitIdxNext = bitIdx + 3'd1;
          if (bitIdx == 3'd7) rxStateNext = RX_STOP;
        end
      RX_STOP:
        if (rxCnt == BIT_M1) begin
          rxCntNext   = '0;
          rxStateNext = RX_IDLE;
          if (rxSync) byteValidNext = !i_reload;
          else        frameSet      = 1'b1;
        end
      default: rxStateNext = RX_IDLE;
    endcase
    if (!rstSyncN) begin
      rxStateNext   = RX_IDLE;
      rxCntNext     = '0;
      bitIdxNext    = '0;
      shiftNext     = '0;
      byteValidNext = 1'b0;
      frameSet      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      rxMeta    <= 1'b1;
      rxSync    <= 1'b1;
      rxPrev    <= 1'b1;
      rxState   <= RX_IDLE;
      rxCnt     <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      byteValid <= 1'b0;
    end else begin
      rxMeta    <= rstSyncN ? i_rx : 1'b1;
      rxSync    <= rstSyncN ? rxMeta : 1'b1;
      rxPrev    <= rstSyncN ? rxSync : 1'b1;
      rxState   <= rxStateNext;
      rxCnt     <= rxCntNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
      byteValid <= byteValidNext;
    end

  // A length byte of 0 encodes a full 256-byte program.
  always_comb begin
    ldStateNext  = ldState;
    idxNext      = idx;
    remNext      = rem;
    addrNext     = o_ramAddress;
    dataNext     = o_ramWriteData;
    weNext       = 1'b0;
    frameErrNext = o_frameErr | frameSet;
    if (i_reload) begin
      ldStateNext  = LD_WAIT_LEN;
      idxNext      = '0;
      frameErrNext = 1'b0;
    end else begin
      case (ldState)
        LD_WAIT_LEN:
          if (byteValid) begin
            remNext     = {shiftReg == 8'd0, shiftReg};
            ldStateNext = LD_LOAD;
          end
        LD_LOAD:
          if (o_ramWriteEn && rem == 9'd0) ldStateNext = LD_DONE;
          else if (byteValid && rem != 9'd0) begin
            weNext   = 1'b1;
            addrNext = idx;
            dataNext = shiftReg;
            idxNext  = idx + 8'd1;
            remNext  = rem - 9'd1;
          end
        LD_DONE: ;
        default: ldStateNext = LD_WAIT_LEN;
      endcase
    end
    if (!rstSyncN) begin
      ldStateNext  = LD_WAIT_LEN;
      idxNext      = '0;
      remNext      = '0;
      addrNext     = '0;
      dataNext     = '0;
      weNext       = 1'b0;
      frameErrNext = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      ldState        <= LD_WAIT_LEN;
      idx            <= '0;
      rem            <= '0;
      o_ramAddress   <= '0;
      o_ramWriteData <= '0;
      o_ramWriteEn   <= 1'b0;
      o_frameErr     <= 1'b0;
    end else begin
      ldState        <= ldStateNext;
      idx            <= idxNext;
      rem            <= remNext;
      o_ramAddress   <= addrNext;
      o_ramWriteData <= dataNext;
      o_ramWriteEn   <= weNext;
      o_frameErr     <= frameErrNext;
    end

  assign o_cpuReset = (ldState == LD_DONE);
  assign o_busy     = (ldState != LD_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader at 4 clocks per bit; strobes are captured by a monitor.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int CPB = 4;

  logic       i_clk = 1'b0, i_reset = 1'b0, i_rx = 1'b1, i_reload = 1'b0;
  logic [7:0] o_ramAddress, o_ramWriteData;
  logic       o_ramWriteEn, o_cpuReset, o_busy, o_frameErr;

  prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx(i_rx), .i_reload(i_reload),
    .o_ramAddress(o_ramAddress), .o_ramWriteData(o_ramWriteData),
    .o_ramWriteEn(o_ramWriteEn), .o_cpuReset(o_cpuReset), .o_busy(o_busy),
    .o_frameErr(o_frameErr)
  );

  always #5 i_clk = ~i_clk;

  int nChk = 0, nPass = 0;
  int cyc = 0, lastStrobeCyc = 0, riseCyc = 0, wideCnt = 0;
  logic prevWe = 1'b0, prevCpu = 1'b0;
  int q[$];

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (o_ramWriteEn) begin
      q.push_back({16'd0, o_ramAddress, o_ramWriteData});
      lastStrobeCyc = cyc;
      if (prevWe) wideCnt++;
    end
    if (o_cpuReset && !prevCpu) riseCyc = cyc;
    prevWe  = o_ramWriteEn;
    prevCpu = o_cpuReset;
  end

  task automatic chk(input string tag, input int got, input int exp);
    nChk++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bitOut(input logic v);
    i_rx = v;
    repeat (CPB) @(posedge i_clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit = 1'b1);
    bitOut(1'b0);
    for (int i = 0; i < 8; i++) bitOut(b[i]);
    bitOut(stopBit);
    i_rx = 1'b1;
    repeat (2 * CPB) @(posedge i_clk);
    #1;
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulseReload();
    i_reload = 1'b1;
    waitCyc(1);
    i_reload = 1'b0;
  endtask

  task automatic expStrobe(input string tag, input int k, input int addr, input int data);
    int e;
    e = (k < q.size()) ? q[k] : -1;
    chk({tag, "_addr"}, (e >> 8) & 255, addr);
    chk({tag, "_data"}, e & 255, data);
  endtask

  task automatic chkResetOuts(input string tag);
    chk({tag, "_addr"}, o_ramAddress, 0);
    chk({tag, "_data"}, o_ramWriteData, 0);
    chk({tag, "_we"}, o_ramWriteEn, 0);
    chk({tag, "_cpu"}, o_cpuReset, 0);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_ferr"}, o_frameErr, 0);
  endtask

  initial begin
    waitCyc(3);
    chkResetOuts("rst");
    i_reset = 1'b1;
    waitCyc(4);

    // Basic 3-byte load
    sendByte(8'h03); sendByte(8'hA1); sendByte(8'hB2); sendByte(8'hC3);
    chk("basic_cnt", q.size(), 3);
    expStrobe("basic0", 0, 0, 'hA1);
    expStrobe("basic1", 1, 1, 'hB2);
    expStrobe("basic2", 2, 2, 'hC3);
    chk("basic_cpu", o_cpuReset, 1);
    chk("basic_busy", o_busy, 0);
    chk("basic_lat", riseCyc - lastStrobeCyc, 1);

    // Bytes arriving in DONE are ignored
    sendByte(8'h99);
    chk("done_ign", q.size(), 3);
    chk("done_cpu", o_cpuReset, 1);

    // Reload, then a short glitch must not produce a byte
    pulseReload();
    chk("rl_cpu", o_cpuReset, 0);
    chk("rl_busy", o_busy, 1);
    q.delete();
    i_rx = 1'b0; waitCyc(2); i_rx = 1'b1; waitCyc(20);
    chk("glitch_cnt", q.size(), 0);
    chk("glitch_ferr", o_frameErr, 0);
    // If the glitch were taken as a length byte, 0x01 would become payload
    sendByte(8'h05, 1'b0);
    chk("ferr_set", o_frameErr, 1);
    chk("ferr_busy", o_busy, 1);
    sendByte(8'h01); sendByte(8'h7E);
    chk("ferr_cnt", q.size(), 1);
    expStrobe("ferr", 0, 0, 'h7E);
    chk("ferr_cpu", o_cpuReset, 1);
    chk("ferr_sticky", o_frameErr, 1);

    // Reload from DONE clears the flag and accepts a new load
    pulseReload();
    chk("rl2_cpu", o_cpuReset, 0);
    chk("rl2_busy", o_busy, 1);
    chk("rl2_ferr", o_frameErr, 0);
    q.delete();
    sendByte(8'h01); sendByte(8'h55);
    chk("rl2_cnt", q.size(), 1);
    expStrobe("rl2", 0, 0, 'h55);
    chk("rl2_done", o_cpuReset, 1);

    // Length 0 means 256 bytes
    pulseReload();
    q.delete();
    sendByte(8'h00);
    for (int i = 0; i < 255; i++) sendByte(8'(i));
    chk("full_early", o_busy, 1);
    sendByte(8'hFF);
    chk("full_cnt", q.size(), 256);
    begin
      int bad = 0;
      for (int i = 0; i < 256; i++)
        if (i >= q.size() || q[i] != ((i << 8) | i)) bad++;
      chk("full_seq_bad", bad, 0);
    end
    chk("full_done", o_cpuReset, 1);

    // Reset during the second payload byte
    pulseReload();
    q.delete();
    sendByte(8'h03); sendByte(8'h11);
    bitOut(1'b0); bitOut(1'b0); bitOut(1'b1); bitOut(1'b0);
    i_reset = 1'b0; i_rx = 1'b1;
    #1;
    chkResetOuts("midrst");
    waitCyc(5);
    i_reset = 1'b1;
    waitCyc(10);
    chk("midrst_cnt", q.size(), 1);
    expStrobe("midrst", 0, 0, 'h11);
    q.delete();
    sendByte(8'h02); sendByte(8'hAA); sendByte(8'hBB);
    chk("post_cnt", q.size(), 2);
    expStrobe("post0", 0, 0, 'hAA);
    expStrobe("post1", 1, 1, 'hBB);
    chk("post_done", o_cpuReset, 1);

    chk("strobe_wide", wideCnt, 0);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit; legal range 4..4095.
REQ-002 i_clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 i_rx  input  1  UART serial data (8N1, LSB first, idle high); asynchronous to i_clk.
REQ-005 i_reload  input  1  synchronous one-cycle request to restart loading.
REQ-006 o_ramAddress  output  8  RAM write address.
REQ-007 o_ramWriteData  output  8  RAM write data.
REQ-008 o_ramWriteEn  output  1  one-cycle RAM write strobe.
REQ-009 o_cpuReset  output  1  active-low CPU hold; 0 while loading, 1 when the program is complete.
REQ-010 o_busy  output  1  high in every state except DONE.
REQ-011 o_frameErr  output  1  sticky framing-error flag.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer; all receiver decisions SHALL use the synchronized value.
REQ-013 Receiver states SHALL be IDLE, START, DATA, STOP; IDLE->START on the synchronized rx going 1->0.
REQ-014 START SHALL sample at CLKS_PER_BIT/2 (integer) cycles; if sample=1 -> IDLE (false start, no byte), else -> DATA.
REQ-015 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals, LSB first, then -> STOP.
REQ-016 STOP SHALL sample CLKS_PER_BIT later; sample=1 -> byte-valid pulse for one cycle; sample=0 -> no byte, o_frameErr<=1; both -> IDLE.
REQ-017 Loader states SHALL be WAIT_LEN, LOAD, DONE.
REQ-018 WAIT_LEN: first valid byte is length N; N=0 means 256; 9-bit remaining count <= N (0 -> 256); -> LOAD.
REQ-019 LOAD: each valid byte SHALL produce o_ramWriteEn=1 for exactly one cycle, on the cycle after the byte-valid pulse, with o_ramWriteData=byte and o_ramAddress=current write index.
REQ-020 The write index SHALL start at 0 and increment by 1 after each strobe, wrapping 255->0; the remaining count SHALL decrement per strobe.
REQ-021 When the remaining count reaches 0 after a strobe, the loader SHALL enter DONE on the next cycle: o_cpuReset=1, o_busy=0.
REQ-022 In DONE, received bytes SHALL be ignored and no strobes issued.
REQ-023 i_reload=1 in any state SHALL, on that edge, go to WAIT_LEN, set index 0, o_cpuReset=0, o_busy=1, clear o_frameErr, and suppress any strobe/byte-valid pulse in that cycle; the receiver FSM SHALL continue undisturbed.
REQ-024 A framing error SHALL not change loader state, index or count; the loader waits for the next valid byte.
REQ-025 o_ramAddress and o_ramWriteData SHALL hold their last values between strobes.

Reset
REQ-026 While i_reset=0, outputs SHALL be: o_ramAddress=0, o_ramWriteData=0, o_ramWriteEn=0, o_cpuReset=0, o_busy=1, o_frameErr=0; receiver in IDLE; loader in WAIT_LEN; synchronizer flops=1.
REQ-027 Reset assertion mid-frame or mid-load SHALL abort immediately; partially received bytes SHALL be discarded, and no strobe SHALL be issued on release.
REQ-028 Reset release SHALL be synchronized internally so that the first state change occurs no earlier than the second rising edge after deassertion.

Verification (CLKS_PER_BIT=4)
REQ-029 Frames 0x03,0xA1,0xB2,0xC3 -> strobes (0,A1),(1,B2),(2,C3), each exactly 1 cycle wide; o_cpuReset 0->1 one cycle after the third strobe; o_busy=0.
REQ-030 Length 0x00 followed by 256 bytes (value = index) -> 256 strobes at addresses 0..255, with no early DONE; DONE after the last strobe.
REQ-031 2-cycle low glitch on i_rx, then idle -> no byte and no strobe; state unchanged.
REQ-032 Frame 0x05 with stop bit=0 -> o_frameErr=1 and loader stays in WAIT_LEN; then valid 0x01,0x7E -> strobe (0,7E), DONE, o_frameErr remains 1.
REQ-033 In DONE: i_reload pulse -> o_cpuReset=0, o_busy=1, o_frameErr=0; a new load of 0x01,0x55 -> strobe (0,55).
REQ-034 i_reset asserted during the data bits of the 2nd payload byte -> outputs at reset values; after release, a full new load succeeds from address 0.
